// File: rtl/saif_mon_pkg.sv
// Shared types for the SAIF-style activity monitor: FSM state encoding and per-bit counter bundle.
// Counter fields are sized for the widest supported counter; narrower builds zero-extend into them.
package saif_mon_pkg;

    parameter int SAIF_CNT_W_DEF = 16;
    localparam int SAIF_CNT_W_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } saif_mon_state_e;

    typedef struct packed {
        logic [SAIF_CNT_W_MAX-1:0] t0;
        logic [SAIF_CNT_W_MAX-1:0] t1;
        logic [SAIF_CNT_W_MAX-1:0] tc;
    } saif_cnt_s;

endpackage

// File: rtl/saif_activity_monitor_bit_counter.sv
// One watched bit: previous sample, T0/T1/TC counters and a sticky overflow flag.
// Macro SAIF_MON_SATURATE_EN makes counters saturate instead of wrapping.
module saif_bit_counter
    import saif_mon_pkg::*;
#(
    parameter int CNT_W = SAIF_CNT_W_DEF
)
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      en,
    input  logic      bit_in,
    output saif_cnt_s cnt,
    output logic      ovf
);

    logic [CNT_W-1:0] r_t0;
    logic [CNT_W-1:0] r_t1;
    logic [CNT_W-1:0] r_tc;
    logic             r_prev;
    logic             r_have_prev;
    logic             r_ovf;

    logic w_inc_t0;
    logic w_inc_t1;
    logic w_inc_tc;
    logic w_ovf_hit;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef SAIF_MON_SATURATE_EN
        return (&c) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    // Increment requests; an all-ones counter asked to count is an overflow in either mode.
    always_comb begin
        w_inc_t0  = en & ~bit_in;
        w_inc_t1  = en & bit_in;
        w_inc_tc  = en & r_have_prev & (bit_in ^ r_prev);
        w_ovf_hit = (w_inc_t0 & (&r_t0)) | (w_inc_t1 & (&r_t1)) | (w_inc_tc & (&r_tc));
    end

    // Counter state; clear wins over a sample so a fresh run starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t0        <= '0;
            r_t1        <= '0;
            r_tc        <= '0;
            r_prev      <= 1'b0;
            r_have_prev <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clr) begin
            r_t0        <= '0;
            r_t1        <= '0;
            r_tc        <= '0;
            r_prev      <= 1'b0;
            r_have_prev <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (en) begin
            if (w_inc_t0) r_t0 <= bump(r_t0);
            if (w_inc_t1) r_t1 <= bump(r_t1);
            if (w_inc_tc) r_tc <= bump(r_tc);
            if (w_ovf_hit) r_ovf <= 1'b1;
            r_prev      <= bit_in;
            r_have_prev <= 1'b1;
        end
    end

    // Zero-extend the counters into the shared bundle.
    always_comb begin
        cnt                = '0;
        cnt.t0[CNT_W-1:0]  = r_t0;
        cnt.t1[CNT_W-1:0]  = r_t1;
        cnt.tc[CNT_W-1:0]  = r_tc;
    end

    assign ovf = r_ovf;

endmodule

// File: rtl/saif_activity_monitor.sv
// SAIF-style activity monitor top: run-control FSM, per-bit counters, registered readback.
// Macro SAIF_MON_SATURATE_EN selects saturating counters (default: wrap-around).
module saif_activity_monitor
    import saif_mon_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = SAIF_CNT_W_DEF,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] sig,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_t0,
    output logic [CNT_W-1:0] rd_t1,
    output logic [CNT_W-1:0] rd_tc,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    saif_mon_state_e r_state;
    saif_mon_state_e w_state_nxt;
    logic            r_busy;
    logic            r_done;
    logic            w_clr;
    logic            w_en;
    saif_cnt_s       w_cnt [WIDTH];
    logic [WIDTH-1:0] w_ovf_bits;
    saif_cnt_s       w_sel;
    logic [CNT_W-1:0] r_rd_t0;
    logic [CNT_W-1:0] r_rd_t1;
    logic [CNT_W-1:0] r_rd_tc;

    // Next-state logic: stop wins in RUN, start wins in IDLE/DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;  else w_state_nxt = ST_IDLE;
            ST_RUN:  if (stop)  w_state_nxt = ST_DONE; else w_state_nxt = ST_RUN;
            ST_DONE: if (start) w_state_nxt = ST_RUN;  else w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The sample coinciding with stop is excluded from the statistics.
    assign w_clr = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
    assign w_en  = (r_state == ST_RUN) && sample_en && !stop;

    // State register with busy/done decoded from the next state so they move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        saif_bit_counter #(
            .CNT_W (CNT_W)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .clr    (w_clr),
            .en     (w_en),
            .bit_in (sig[gi]),
            .cnt    (w_cnt[gi]),
            .ovf    (w_ovf_bits[gi])
        );
    end

    // Readback select; indices past the vector return zeros.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rd_idx == IDX_W'(i)) w_sel = w_cnt[i];
        end
    end

    // Registered readback, one cycle behind rd_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_t0 <= '0;
            r_rd_t1 <= '0;
            r_rd_tc <= '0;
        end else begin
            r_rd_t0 <= w_sel.t0[CNT_W-1:0];
            r_rd_t1 <= w_sel.t1[CNT_W-1:0];
            r_rd_tc <= w_sel.tc[CNT_W-1:0];
        end
    end

    assign rd_t0 = r_rd_t0;
    assign rd_t1 = r_rd_t1;
    assign rd_tc = r_rd_tc;
    assign busy  = r_busy;
    assign done  = r_done;
    assign ovf   = |w_ovf_bits;

endmodule

// File: tb/tb_saif_activity_monitor.sv
// Directed, table-driven bench for saif_activity_monitor (16-bit and 2-bit counter instances).
// Honours SAIF_MON_SATURATE_EN for the overflow expectations.
module tb_saif_activity_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        sample_en;
    logic [4:0]  sig;
    logic [2:0]  rd_idx;
    logic [15:0] rd_t0, rd_t1, rd_tc;
    logic        busy, done, ovf;
    logic [1:0]  s_t0, s_t1, s_tc;
    logic        s_busy, s_done, s_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       en;
        logic [4:0] sig;
        logic       busy;
        logic       done;
    } cyc_t;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] t0;
        logic [15:0] t1;
        logic [15:0] tc;
    } rd_t;

    cyc_t seq2 [6];
    rd_t  rb2  [7];
    rd_t  rb3  [5];

    always #5 clk = ~clk;

    saif_activity_monitor #(.WIDTH(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
        .sig(sig), .rd_idx(rd_idx), .rd_t0(rd_t0), .rd_t1(rd_t1), .rd_tc(rd_tc),
        .busy(busy), .done(done), .ovf(ovf)
    );

    saif_activity_monitor #(.WIDTH(5), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
        .sig(sig), .rd_idx(rd_idx), .rd_t0(s_t0), .rd_t1(s_t1), .rd_tc(s_tc),
        .busy(s_busy), .done(s_done), .ovf(s_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; sample_en = 1'b0; sig = 5'b00000;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_seq2();
        for (int i = 0; i < 6; i++) begin
            start = seq2[i].start; stop = seq2[i].stop;
            sample_en = seq2[i].en; sig = seq2[i].sig;
            tick();
            chk($sformatf("seq2[%0d].busy", i), 32'(busy), 32'(seq2[i].busy));
            chk($sformatf("seq2[%0d].done", i), 32'(done), 32'(seq2[i].done));
        end
        idle_inputs();
    endtask

    task automatic read_row(input string tag, input rd_t r);
        rd_idx = r.idx;
        tick();
        chk($sformatf("%s idx%0d t0", tag, r.idx), 32'(rd_t0), 32'(r.t0));
        chk($sformatf("%s idx%0d t1", tag, r.idx), 32'(rd_t1), 32'(r.t1));
        chk($sformatf("%s idx%0d tc", tag, r.idx), 32'(rd_tc), 32'(r.tc));
    endtask

    initial begin
        logic [1:0] exp_sat;
        seq2[0] = '{1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0};
        seq2[1] = '{1'b0, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0};
        seq2[2] = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 1'b0};
        seq2[3] = '{1'b0, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0};
        seq2[4] = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 1'b0};
        seq2[5] = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) rb2[i] = '{3'(i), 16'd2, 16'd2, 16'd3};
        rb2[5] = '{3'd5, 16'd0, 16'd0, 16'd0};
        rb2[6] = '{3'd7, 16'd0, 16'd0, 16'd0};
        rb3[0] = '{3'd0, 16'd4, 16'd4, 16'd7};
        rb3[1] = '{3'd1, 16'd8, 16'd0, 16'd0};
        rb3[2] = '{3'd2, 16'd8, 16'd0, 16'd0};
        rb3[3] = '{3'd3, 16'd8, 16'd0, 16'd0};
        rb3[4] = '{3'd4, 16'd0, 16'd8, 16'd0};

        // 1: reset state
        idle_inputs();
        rd_idx = 3'd0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst rd_t0", 32'(rd_t0), 32'd0);
        chk("rst rd_t1", 32'(rd_t1), 32'd0);
        chk("rst rd_tc", 32'(rd_tc), 32'd0);

        // 2: alternating full vector, stop-cycle sample excluded
        run_seq2();
        for (int i = 0; i < 7; i++) read_row("s2", rb2[i]);
        chk("s2 ovf", 32'(ovf), 32'd0);

        // 3: DONE -> RUN, bit0 toggling with a two-sample gap, bit4 held high
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s3 busy", 32'(busy), 32'd1);
        chk("s3 done", 32'(done), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            sig = {1'b1, 3'b000, ((k % 2) == 0) ? 1'b1 : 1'b0};
            sample_en = !(k == 4 || k == 5);
            tick();
        end
        stop = 1'b1; sample_en = 1'b1;
        tick();
        idle_inputs();
        chk("s3 stop done", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) read_row("s3", rb3[i]);

        // 4: start+stop in IDLE, then start+stop in RUN, counters frozen in DONE
        pulse_rst();
        start = 1'b1; stop = 1'b1;
        tick();
        chk("s4 idle ss busy", 32'(busy), 32'd1);
        chk("s4 idle ss done", 32'(done), 32'd0);
        start = 1'b0; stop = 1'b0; sample_en = 1'b1; sig = 5'b11111;
        repeat (2) tick();
        start = 1'b1; stop = 1'b1; sig = 5'b00000;
        tick();
        chk("s4 run ss busy", 32'(busy), 32'd0);
        chk("s4 run ss done", 32'(done), 32'd1);
        start = 1'b0; stop = 1'b0;
        repeat (2) tick();
        idle_inputs();
        read_row("s4", '{3'd3, 16'd0, 16'd2, 16'd0});

        // 5: 2-bit counters overflow on bit2 held high for five samples
        pulse_rst();
        start = 1'b1;
        tick();
        start = 1'b0; sample_en = 1'b1; sig = 5'b00100;
        repeat (5) tick();
        stop = 1'b1; sample_en = 1'b0;
        tick();
        idle_inputs();
        rd_idx = 3'd2;
        tick();
`ifdef SAIF_MON_SATURATE_EN
        exp_sat = 2'd3;
`else
        exp_sat = 2'd1;
`endif
        chk("s5 narrow t1", 32'(s_t1), 32'(exp_sat));
        chk("s5 narrow ovf", 32'(s_ovf), 32'd1);
        chk("s5 wide t1", 32'(rd_t1), 32'd5);
        chk("s5 wide ovf", 32'(ovf), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s5 restart ovf", 32'(s_ovf), 32'd0);

        // 6: async reset mid-RUN discards everything, rerun reproduces scenario 2
        pulse_rst();
        start = 1'b1;
        tick();
        start = 1'b0; sample_en = 1'b1; sig = 5'b11111;
        repeat (6) tick();
        sample_en = 1'b0; rd_idx = 3'd4;
        tick();
        chk("s6 pre-rst t1", 32'(rd_t1), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk("s6 async rd_t1", 32'(rd_t1), 32'd0);
        chk("s6 async busy", 32'(busy), 32'd0);
        tick();
        chk("s6 rst rd_t0", 32'(rd_t0), 32'd0);
        chk("s6 rst rd_tc", 32'(rd_tc), 32'd0);
        chk("s6 rst done", 32'(done), 32'd0);
        chk("s6 rst ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();
        run_seq2();
        for (int i = 0; i < 7; i++) read_row("s6", rb2[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
